buzzer_sound_arbiter: RTL and testbench

Shares the single buzzer tone generator among the oven's sound sources: a level-driven danger alarm and three pulse-triggered beep sequences (key click, cook-end, timer tick). Latches requests, sequences each source's beep pattern, and drives the tone generator with a half-period and an enable. Sits between the control FSMs and the buzzer divider.

---
 rtl/buzzer_sound_arbiter_pkg.sv | 35 +++
 rtl/buzzer_sound_arbiter_if.sv | 17 +
 rtl/buzzer_sound_arbiter_timer.sv | 20 ++
 rtl/buzzer_sound_arbiter.sv | 116 +++++++++++
 tb/tb_buzzer_sound_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/buzzer_sound_arbiter_pkg.sv
// buzzer_sound_pkg: states, source indices, beep pattern table, alarm constants and count scaling
package buzzer_sound_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_ALARM} state_e;

    localparam logic [1:0] SRC_KEY  = 2'd0;
    localparam logic [1:0] SRC_COOK = 2'd1;
    localparam logic [1:0] SRC_TICK = 2'd2;
    localparam int         TW       = 27;
    localparam int         HP_W     = 16;

    typedef struct packed {
        logic [1:0]      beeps;
        logic [31:0]     on_cyc;
        logic [31:0]     off_cyc;
        logic [HP_W-1:0] half;
    } pattern_t;

    localparam logic [31:0]     ALARM_SLOT = 32'd20_000_000;
    localparam logic [HP_W-1:0] ALARM_HI   = 16'd16_667;
    localparam logic [HP_W-1:0] ALARM_LO   = 16'd40_000;

    function automatic pattern_t pattern(input logic [1:0] s);
        return s == SRC_KEY  ? pattern_t'{2'd1, 32'd7_000_000,  32'd1,          16'd25_000} :
               s == SRC_COOK ? pattern_t'{2'd3, 32'd25_000_000, 32'd75_000_000, 16'd50_000} :
                               pattern_t'{2'd2, 32'd10_000_000, 32'd10_000_000, 16'd12_500};
    endfunction

    function automatic logic [TW-1:0] scaled(input logic [31:0] cyc, input int unsigned div);
        logic [31:0] q;
        q = div == 0 ? cyc : cyc / div;
        return q == 32'd0 ? TW'(1) : q[TW-1:0];
    endfunction

endpackage

// File: rtl/buzzer_sound_arbiter_if.sv
// buzzer_sound_arbiter_if: request side and tone-generator side of the buzzer arbiter
interface buzzer_sound_arbiter_if;
    import buzzer_sound_pkg::*;
    logic            alarm_level;
    logic [2:0]      req;
    logic            cancel;
    logic [HP_W-1:0] tone_half_period;
    logic            tone_en;
    logic [1:0]      active_src;
    logic            busy;
    logic [2:0]      done;

    modport master (output alarm_level, req, cancel,
                    input  tone_half_period, tone_en, active_src, busy, done);
    modport slave  (input  alarm_level, req, cancel,
                    output tone_half_period, tone_en, active_src, busy, done);
endinterface

// File: rtl/buzzer_sound_arbiter_timer.sv
// beep_phase_timer: loadable down-counter; expired while the count sits at zero
module beep_phase_timer
    import buzzer_sound_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          expired
);
    logic [TW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - TW'(1) : cnt_q);

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign expired = cnt_q == '0;
endmodule

// File: rtl/buzzer_sound_arbiter.sv
// buzzer_sound_arbiter: shares one tone generator between the danger alarm and three beep sequences
module buzzer_sound_arbiter
    import buzzer_sound_pkg::*;
#(
    parameter int unsigned SIM_DIV = 1
) (
    input logic                   clk,
    input logic                   reset,
    buzzer_sound_arbiter_if.slave bus
);
    state_e          state_q, state_d;
    logic [1:0]      src_q, src_d, beep_q, beep_d, first, active_q, active_d;
    logic [2:0]      pending_q, pending_d, launch, requeue, playing_mask, done_q, done_d;
    logic            hi_q, hi_d, playing, ld, expired, en_q, en_d, busy_q, busy_d;
    logic [TW-1:0]   ld_val;
    logic [HP_W-1:0] hp_q, hp_d;
    pattern_t        cur, nxt;

    beep_phase_timer u_timer (.clk, .reset, .load(ld), .load_val(ld_val), .expired);

    assign first        = pending_q[0] ? SRC_KEY : pending_q[1] ? SRC_COOK : SRC_TICK;
    assign cur          = pattern(src_q);
    assign playing      = state_q == S_ON || state_q == S_OFF;
    assign playing_mask = playing ? 3'b001 << src_q : 3'b000;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        beep_d  = beep_q;
        hi_d    = hi_q;
        done_d  = '0;
        launch  = '0;
        requeue = '0;
        ld      = 1'b0;
        ld_val  = '0;
        // alarm preempts everything; an interrupted sequence goes back into the queue
        if (bus.alarm_level) begin
            state_d = S_ALARM;
            if (state_q != S_ALARM || expired) begin
                hi_d   = state_q != S_ALARM ? 1'b1 : ~hi_q;
                ld     = 1'b1;
                ld_val = scaled(ALARM_SLOT, SIM_DIV) - TW'(1);
            end
            requeue = state_q != S_ALARM ? playing_mask : 3'b000;
        end else begin
            case (state_q)
                S_IDLE: if (pending_q != '0 && !bus.cancel) begin
                    state_d = S_ON;
                    src_d   = first;
                    beep_d  = 2'd1;
                    launch  = 3'b001 << first;
                    ld      = 1'b1;
                    ld_val  = scaled(pattern(first).on_cyc, SIM_DIV) - TW'(1);
                end
                S_ON: if (bus.cancel) state_d = S_IDLE;
                else if (expired) begin
                    state_d = S_OFF;
                    ld      = 1'b1;
                    ld_val  = scaled(cur.off_cyc, SIM_DIV) - TW'(1);
                end
                S_OFF: if (bus.cancel) state_d = S_IDLE;
                else if (expired && beep_q < cur.beeps) begin
                    state_d = S_ON;
                    beep_d  = beep_q + 2'd1;
                    ld      = 1'b1;
                    ld_val  = scaled(cur.on_cyc, SIM_DIV) - TW'(1);
                end else if (expired) begin
                    state_d = S_IDLE;
                    done_d  = 3'b001 << src_q;
                end
                default: begin
                    state_d = S_IDLE;
                    hi_d    = 1'b0;
                end
            endcase
        end
        pending_d = bus.cancel ? 3'b000 : (pending_q & ~launch) | requeue | (bus.req & ~playing_mask);
    end

    assign nxt      = pattern(src_d);
    assign en_d     = state_d == S_ON || state_d == S_ALARM;
    assign hp_d     = state_d == S_ON ? nxt.half : state_d == S_ALARM ? (hi_d ? ALARM_HI : ALARM_LO) : '0;
    assign active_d = state_d == S_ON || state_d == S_OFF ? src_d + 2'd1 : 2'd0;
    assign busy_d   = state_d != S_IDLE;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            beep_q    <= '0;
            hi_q      <= 1'b0;
            pending_q <= '0;
            en_q      <= 1'b0;
            hp_q      <= '0;
            active_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            beep_q    <= beep_d;
            hi_q      <= hi_d;
            pending_q <= pending_d;
            en_q      <= en_d;
            hp_q      <= hp_d;
            active_q  <= active_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end

    assign bus.tone_en          = en_q;
    assign bus.tone_half_period = hp_q;
    assign bus.active_src       = active_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
endmodule

// File: tb/tb_buzzer_sound_arbiter.sv
// tb_buzzer_sound_arbiter: directed scenarios plus random traffic checked every cycle against a timeline model
module tb_buzzer_sound_arbiter;
    localparam int SD = 100_000;

    function automatic int sc(int c);
        return c / SD < 1 ? 1 : c / SD;
    endfunction

    localparam int ON_T[3]  = '{sc(7_000_000), sc(25_000_000), sc(10_000_000)};
    localparam int OFF_T[3] = '{sc(1), sc(75_000_000), sc(10_000_000)};
    localparam int BEEPS[3] = '{1, 3, 2};
    localparam int HP_T[3]  = '{25_000, 50_000, 12_500};
    localparam int SLOT     = sc(20_000_000);

    logic clk = 1'b0, reset = 1'b1;
    buzzer_sound_arbiter_if bus();
    buzzer_sound_arbiter #(.SIM_DIV(SD)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int mode, cur, beep, t, at;
    logic [2:0] pend, nreq;
    logic e_en, e_busy;
    logic [15:0] e_hp;
    logic [1:0] e_src;
    logic [2:0] e_done;

    // mode: 0 silent, 1 playing a beep pattern, 2 alarm; t and at count cycles since phase start
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mode = 0; cur = 0; beep = 0; t = 0; at = 0; pend = 0; e_done = 0;
        end else begin
            nreq = bus.req & ~(mode == 1 ? 3'(1 << cur) : 3'b000);
            e_done = 0;
            if (bus.alarm_level) begin
                if (mode == 1) pend[cur] = 1'b1;
                if (mode != 2) begin mode = 2; at = 0; end else at++;
            end else if (mode == 2) mode = 0;
            else if (mode == 0) begin
                if (pend != 0 && !bus.cancel) begin
                    cur = pend[0] ? 0 : pend[1] ? 1 : 2;
                    pend[cur] = 1'b0; mode = 1; beep = 1; t = 0;
                end
            end else if (bus.cancel) mode = 0;
            else begin
                t++;
                if (t == ON_T[cur] + OFF_T[cur]) begin
                    if (beep < BEEPS[cur]) begin beep++; t = 0; end
                    else begin mode = 0; e_done[cur] = 1'b1; end
                end
            end
            pend = bus.cancel ? 3'b000 : pend | nreq;
        end
        e_en   = mode == 1 ? t < ON_T[cur] : mode == 2;
        e_hp   = 16'(mode == 1 && t < ON_T[cur] ? HP_T[cur] : mode == 2 ? ((at / SLOT) % 2 == 0 ? 16_667 : 40_000) : 0);
        e_src  = mode == 1 ? 2'(cur + 1) : 2'd0;
        e_busy = mode != 0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        checks++;
        if (bus.tone_en !== e_en || bus.tone_half_period !== e_hp || bus.active_src !== e_src ||
            bus.busy !== e_busy || bus.done !== e_done) begin
            errors++;
            $display("FAIL model at %0t: en/hp/src/busy/done got %b/%0d/%0d/%b/%b expected %b/%0d/%0d/%b/%b",
                     $time, bus.tone_en, bus.tone_half_period, bus.active_src, bus.busy, bus.done,
                     e_en, e_hp, e_src, e_busy, e_done);
        end
    endtask

    task automatic idle_in();
        bus.req = 3'b000; bus.cancel = 1'b0; bus.alarm_level = 1'b0;
    endtask

    int n, rises, d1, alarm_left;
    logic prev_en, seen;
    int dq[$];

    initial begin
        idle_in();
        repeat (3) step();
        chk("reset_en", int'(bus.tone_en), 0);
        chk("reset_busy", int'(bus.busy), 0);
        reset = 1'b0;
        repeat (5) step();

        // key: 70 cycles of tone, one off cycle, then done[0]
        bus.req = 3'b001; step();
        chk("key_pending_en", int'(bus.tone_en), 0);
        bus.req = 3'b000; step();
        chk("key_en", int'(bus.tone_en), 1);
        chk("key_hp", int'(bus.tone_half_period), 25_000);
        chk("key_src", int'(bus.active_src), 1);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!bus.tone_en) break;
            n++;
        end
        chk("key_on_len", n, 70);
        chk("key_off_done", int'(bus.done), 0);
        step();
        chk("key_done", int'(bus.done), 1);
        chk("key_idle", int'(bus.busy), 0);
        repeat (5) step();

        // cook-end: three bursts then done[1]
        bus.req = 3'b010; step(); bus.req = 3'b000;
        rises = 0; d1 = 0; prev_en = 1'b0;
        for (int i = 0; i < 3200; i++) begin
            step();
            if (bus.tone_en && !prev_en) rises++;
            if (bus.done[1]) d1++;
            prev_en = bus.tone_en;
        end
        chk("cook_bursts", rises, 3);
        chk("cook_done", d1, 1);

        // all three at once: done order key, cook-end, tick
        bus.req = 3'b111; step(); bus.req = 3'b000;
        dq.delete();
        for (int i = 0; i < 3700; i++) begin
            step();
            if (bus.done != 0) dq.push_back(int'(bus.done));
        end
        chk("order_cnt", dq.size(), 3);
        if (dq.size() == 3) begin
            chk("order_0", dq[0], 1);
            chk("order_1", dq[1], 2);
            chk("order_2", dq[2], 4);
        end

        // cook-end interrupted by the alarm during beep 2
        bus.req = 3'b010; step(); bus.req = 3'b000;
        repeat (1100) step();
        bus.alarm_level = 1'b1; step();
        chk("alarm_hi", int'(bus.tone_half_period), 16_667);
        chk("alarm_src", int'(bus.active_src), 0);
        repeat (200) step();
        chk("alarm_lo", int'(bus.tone_half_period), 40_000);
        repeat (299) step();
        bus.alarm_level = 1'b0; step();
        chk("alarm_off", int'(bus.tone_en), 0);
        d1 = 0; rises = 0; prev_en = 1'b0;
        for (int i = 0; i < 3200; i++) begin
            step();
            if (bus.done[1]) d1++;
            if (bus.tone_en && !prev_en) rises++;
            prev_en = bus.tone_en;
        end
        chk("restart_bursts", rises, 3);
        chk("restart_done", d1, 1);

        // tick playing with key pending, then cancel
        bus.req = 3'b100; step(); bus.req = 3'b000;
        repeat (20) step();
        bus.req = 3'b001; step(); bus.req = 3'b000;
        repeat (5) step();
        bus.cancel = 1'b1; step(); bus.cancel = 1'b0;
        chk("cancel_en", int'(bus.tone_en), 0);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (bus.active_src == 2'd1 || bus.done != 0) seen = 1'b1;
        end
        chk("cancel_quiet", int'(seen), 0);

        // asynchronous reset during an ON phase
        bus.req = 3'b100; step(); bus.req = 3'b000;
        for (int i = 0; i < 10 && !bus.tone_en; i++) step();
        chk("pre_reset_en", int'(bus.tone_en), 1);
        @(posedge clk); #2 reset = 1'b1; #1;
        chk("async_reset_outs", int'({bus.tone_en, bus.busy, bus.active_src, bus.done}), 0);
        chk("async_reset_hp", int'(bus.tone_half_period), 0);
        repeat (2) step();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (bus.busy) seen = 1'b1;
        end
        chk("post_reset_idle", int'(seen), 0);

        // random traffic against the model
        alarm_left = 0;
        for (int i = 0; i < 15000; i++) begin
            bus.req = 3'b000; bus.cancel = 1'b0;
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 399) == 0) bus.req[b] = 1'b1;
            if ($urandom_range(0, 2999) == 0) bus.cancel = 1'b1;
            if (alarm_left > 0) alarm_left--;
            else if ($urandom_range(0, 5999) == 0) alarm_left = int'($urandom_range(30, 700));
            bus.alarm_level = alarm_left > 0;
            step();
        end
        idle_in();
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
